// File: rtl/mul8_share_pkg.sv
// Shared types and the round-robin pick used by the shared 8x8 multiplier arbiter.
// Optional statistics counters in the top are enabled by MUL8_SHARE_STATS_EN.
package mul8_share_pkg;

  localparam int OPW    = 8;
  localparam int PW     = 16;
  localparam int MAXREQ = 16;
  localparam int MAXIDW = 4;

  typedef logic [OPW-1:0]    op_t;
  typedef logic [PW-1:0]     prod_t;
  typedef logic [MAXIDW-1:0] id_t;

  typedef struct packed {
    op_t a;
    op_t b;
    id_t id;
  } s1_t;

  // One-hot grant for the first valid requester at or after ptr, wrapping at nreq.
  function automatic logic [MAXREQ-1:0] rr_pick(
    input logic [MAXREQ-1:0] valid,
    input id_t               ptr,
    input logic [MAXIDW:0]   nreq
  );
    logic [MAXREQ-1:0] grant;
    logic [MAXIDW:0]   idx;
    logic              found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < MAXREQ; i++) begin
      idx = {1'b0, ptr} + i[MAXIDW:0];
      if (idx >= nreq) idx = idx - nreq;
      if (!found && (i[MAXIDW:0] < nreq) && valid[idx[MAXIDW-1:0]]) begin
        grant[idx[MAXIDW-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/mul8_share_arb_core.sv
// Exact combinational 8x8 unsigned multiplier; an approximate core with the
// same ports can be dropped in its place.
module mul8_exact_core
  import mul8_share_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [PW-1:0]  p
);

  assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/mul8_share_arb.sv
// Round-robin sharing of one 8x8 multiplier among NREQ requesters, with an
// operand stage and a result stage. Define MUL8_SHARE_STATS_EN for grant counters.
module mul8_share_arb
  import mul8_share_pkg::*;
#(
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ),
  parameter  int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*OPW-1:0]   req_a,
  input  logic [NREQ*OPW-1:0]   req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [PW-1:0]         rsp_p,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
`ifdef MUL8_SHARE_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [NREQ*CNT_W-1:0] stat_grants
`endif
);

  logic              s1_valid;
  s1_t               s1_q;
  prod_t             prod;
  logic              s2_adv;
  logic              s1_adv;
  logic              xfer;
  logic [IDW-1:0]    xfer_id;
  logic [IDW-1:0]    rr_ptr;
  logic [MAXREQ-1:0] grant_full;
  logic [NREQ-1:0]   grant;
  op_t               a_sel;
  op_t               b_sel;
  logic              unused_bits;

  assign s2_adv = !rsp_valid || rsp_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign busy   = s1_valid | rsp_valid;

  // Grant is only offered when S1 can take a new entry this cycle.
  always_comb begin
    grant_full = rr_pick(MAXREQ'(req_valid), MAXIDW'(rr_ptr), NREQ[MAXIDW:0]);
    grant      = grant_full[NREQ-1:0];
    req_ready  = rst ? '0 : (grant & {NREQ{s1_adv}});
    xfer       = |req_ready;
    xfer_id    = '0;
    a_sel      = '0;
    b_sel      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        xfer_id = i[IDW-1:0];
        a_sel   = req_a[i*OPW +: OPW];
        b_sel   = req_b[i*OPW +: OPW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      if (xfer) begin
        rr_ptr <= (xfer_id == IDW'(NREQ - 1)) ? '0 : xfer_id + IDW'(1);
      end
      if (s1_adv) begin
        s1_valid <= xfer;
        if (xfer) begin
          s1_q.a  <= a_sel;
          s1_q.b  <= b_sel;
          s1_q.id <= MAXIDW'(xfer_id);
        end
      end
    end
  end

  mul8_exact_core u_core (
    .a (s1_q.a),
    .b (s1_q.b),
    .p (prod)
  );

  // Result registers hold while the consumer stalls or the stage is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      rsp_id    <= '0;
    end else if (s2_adv) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_p  <= prod;
        rsp_id <= s1_q.id[IDW-1:0];
      end
    end
  end

`ifdef MUL8_SHARE_STATS_EN
  logic [NREQ-1:0][CNT_W-1:0] grant_cnt;

  // Saturating per-requester transfer counters; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && (grant_cnt[i] != '1)) begin
          grant_cnt[i] <= grant_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign stat_grants = grant_cnt;
  assign unused_bits = ^{s1_q.id, grant_full};
`else
  assign unused_bits = ^{s1_q.id, grant_full, 32'(CNT_W)};
`endif

endmodule

// File: tb/tb_mul8_share_arb.sv
// Directed and scoreboard bench for mul8_share_arb (NREQ=4); the stats section
// is only built when MUL8_SHARE_STATS_EN is defined.
module tb_mul8_share_arb;

  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int CNT_W = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*8-1:0]   req_a;
  logic [NREQ*8-1:0]   req_b;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [15:0]         rsp_p;
  logic [IDW-1:0]      rsp_id;
  logic                busy;
`ifdef MUL8_SHARE_STATS_EN
  logic                stat_clr = 1'b0;
  logic [NREQ*CNT_W-1:0] stat_grants;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int          k;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  typedef struct {
    logic [15:0]    p;
    logic [IDW-1:0] id;
  } sb_t;

  vec_t vecs [10];
  sb_t  sb [$];

  mul8_share_arb #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef MUL8_SHARE_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_grants (stat_grants)
`endif
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*8-1:0] a,
                               input logic [NREQ*8-1:0] b, input logic rr);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [NREQ*8-1:0] slot(input int k, input logic [7:0] v);
    logic [NREQ*8-1:0] r;
    r = '0;
    r[8*k +: 8] = v;
    return r;
  endfunction

  // Nearest valid requester at or after ptr wins.
  function automatic logic [NREQ-1:0] rr_model(input logic [NREQ-1:0] v, input int ptr);
    logic [NREQ-1:0] g;
    logic [IDW-1:0]  idx;
    g = '0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      idx = IDW'((ptr + o) % NREQ);
      if (v[idx]) begin
        g = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  initial begin
    vecs[0] = '{0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{1, 8'h00, 8'hFF, 16'h0000};
    vecs[2] = '{2, 8'h01, 8'h01, 16'h0001};
    vecs[3] = '{3, 8'h80, 8'h02, 16'h0100};
    vecs[4] = '{0, 8'h12, 8'h34, 16'h03A8};
    vecs[5] = '{1, 8'hAA, 8'h55, 16'h3872};
    vecs[6] = '{2, 8'h0F, 8'h0F, 16'h00E1};
    vecs[7] = '{3, 8'hFF, 8'h01, 16'h00FF};
    vecs[8] = '{1, 8'h7F, 8'h81, 16'h3FFF};
    vecs[9] = '{2, 8'hC8, 8'h64, 16'h4E20};

    // Reset with requests pending: nothing may be accepted.
    rst = 1'b1;
    applyStimulus('1, '1, '1, 1'b1);
    @(negedge clk);
    checkOutput("reset_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus('0, '0, '0, 1'b1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rsp_p", 32'(rsp_p), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    checkOutput("idle_ready", 32'(req_ready), 32'd0);
    checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Single transactions, one requester at a time.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      applyStimulus(NREQ'(1 << vecs[i].k), slot(vecs[i].k, vecs[i].a), slot(vecs[i].k, vecs[i].b), 1'b1);
      checkOutput($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(1 << vecs[i].k));
      @(negedge clk);
      applyStimulus('0, '0, '0, 1'b1);
      checkOutput($sformatf("vec%0d_s1_busy", i), 32'({busy, rsp_valid}), 32'b10);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("vec%0d_rsp_p", i), 32'(rsp_p), 32'(vecs[i].p));
      checkOutput($sformatf("vec%0d_rsp_id", i), 32'(rsp_id), 32'(vecs[i].k));
      @(negedge clk);
      checkOutput($sformatf("vec%0d_rsp_gone", i), 32'(rsp_valid), 32'd0);
    end

    // Stall the consumer from empty: two accepts, then S1 and S2 both full.
    @(negedge clk);
    applyStimulus('1, {8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd3}}, 1'b0);
    checkOutput("fill1_onehot", 32'($onehot(req_ready)), 32'd1);
    @(negedge clk);
    checkOutput("fill2_onehot", 32'($onehot(req_ready)), 32'd1);
    @(negedge clk);
    checkOutput("full_ready", 32'(req_ready), 32'd0);
    checkOutput("full_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("full_busy", 32'(busy), 32'd1);

    // Reset mid-stream drops both entries.
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midreset_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus('0, '0, '0, 1'b1);
    checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_rsp_p", 32'(rsp_p), 32'd0);
    @(negedge clk);
    checkOutput("midreset_no_flush", 32'(rsp_valid), 32'd0);

    // All requesters valid: rotating grants, one product per cycle.
    @(negedge clk);
    applyStimulus('1, {8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd3}}, 1'b1);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      checkOutput($sformatf("rr_grant_c%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 2) begin
        checkOutput($sformatf("rr_valid_c%0d", c), 32'(rsp_valid), 32'd1);
        checkOutput($sformatf("rr_id_c%0d", c), 32'(rsp_id), 32'((c - 2) % 4));
        checkOutput($sformatf("rr_p_c%0d", c), 32'(rsp_p), 32'(3 * ((c - 2) % 4 + 1)));
      end
    end

    // Three stalled cycles with the pipeline full, then release.
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      applyStimulus('1, {8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd3}}, 1'b0);
      checkOutput($sformatf("stall%0d_ready", s), 32'(req_ready), 32'd0);
      checkOutput($sformatf("stall%0d_valid", s), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("stall%0d_p", s), 32'(rsp_p), 32'd3);
      checkOutput($sformatf("stall%0d_id", s), 32'(rsp_id), 32'd0);
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      applyStimulus('1, {8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd3}}, 1'b1);
      checkOutput($sformatf("release%0d_id", j), 32'(rsp_id), 32'(j % 4));
      checkOutput($sformatf("release%0d_p", j), 32'(rsp_p), 32'(3 * (j % 4 + 1)));
      checkOutput($sformatf("release%0d_grant", j), 32'(req_ready), 32'(1 << ((j + 2) % 4)));
    end
    @(negedge clk);
    applyStimulus('0, '0, '0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("drain_busy", 32'(busy), 32'd0);

    // Exhaustive operand sweep through random requesters with random backpressure.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    begin : sweep
      logic [15:0]       pend [NREQ];
      bit                has [NREQ];
      int                next_pair;
      int                pending;
      int                ptr_m;
      int                cyc;
      bit                m_s1, m_rsp, s1a, s2a, xf;
      logic              rr;
      logic [NREQ-1:0]   v, exp_g;
      logic [NREQ*8-1:0] av, bv;
      sb_t               e;
      next_pair = 0;
      pending   = 0;
      ptr_m     = 0;
      cyc       = 0;
      m_s1      = 1'b0;
      m_rsp     = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        has[k]  = 1'b0;
        pend[k] = '0;
      end
      while ((next_pair < 65536 || pending != 0 || sb.size() != 0) && cyc < 90000) begin
        @(negedge clk);
        cyc++;
        for (int k = 0; k < NREQ; k++) begin
          if (!has[k] && next_pair < 65536) begin
            pend[k] = next_pair[15:0];
            has[k]  = 1'b1;
            next_pair++;
            pending++;
          end
          v[k] = has[k] && ($urandom_range(0, 3) != 0);
          av[8*k +: 8] = pend[k][15:8];
          bv[8*k +: 8] = pend[k][7:0];
        end
        rr = ($urandom_range(0, 15) != 0);
        applyStimulus(v, av, bv, rr);
        s2a   = !m_rsp || rr;
        s1a   = !m_s1 || s2a;
        exp_g = s1a ? rr_model(v, ptr_m) : '0;
        checkOutput("sweep_ready", 32'(req_ready), 32'(exp_g));
        checkOutput("sweep_rsp_valid", 32'(rsp_valid), 32'(m_rsp));
        if (rsp_valid && rr) begin
          checkOutput("sweep_sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput("sweep_rsp", 32'({rsp_id, rsp_p}), 32'({e.id, e.p}));
          end
        end
        xf = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          if (v[k] && req_ready[k]) begin
            e.p  = 16'(pend[k][15:8]) * 16'(pend[k][7:0]);
            e.id = IDW'(k);
            sb.push_back(e);
            has[k] = 1'b0;
            pending--;
            ptr_m = (k + 1) % NREQ;
            xf    = 1'b1;
          end
        end
        if (s2a) m_rsp = m_s1;
        if (s1a) m_s1 = xf;
      end
      checkOutput("sweep_all_sent", 32'(next_pair), 32'd65536);
      checkOutput("sweep_drained", 32'(sb.size() + pending), 32'd0);
    end
    @(negedge clk);
    applyStimulus('0, '0, '0, 1'b1);

`ifdef MUL8_SHARE_STATS_EN
    // Grant counters: count, clear, saturate.
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    checkOutput("stat_cleared", 32'(stat_grants[2*CNT_W +: CNT_W]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      applyStimulus(4'b0100, slot(2, 8'd1), slot(2, 8'd1), 1'b1);
    end
    @(negedge clk);
    applyStimulus('0, '0, '0, 1'b1);
    checkOutput("stat_slot2_five", 32'(stat_grants[2*CNT_W +: CNT_W]), 32'd5);
    checkOutput("stat_slot0_zero", 32'(stat_grants[0 +: CNT_W]), 32'd0);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    checkOutput("stat_clr_zero", 32'(stat_grants[2*CNT_W +: CNT_W]), 32'd0);
    force dut.grant_cnt = {16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    #1;
    release dut.grant_cnt;
    applyStimulus(4'b0100, slot(2, 8'd1), slot(2, 8'd1), 1'b1);
    @(negedge clk);
    applyStimulus('0, '0, '0, 1'b1);
    checkOutput("stat_saturate", 32'(stat_grants[2*CNT_W +: CNT_W]), 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
